// File: rtl/speed_sampler.sv
// Quadrature encoder speed sampler: per-channel decode and saturating count,
// sampled at a fixed rate into pv_o, with a ramp-limited copy of sp_i in sp_o.
`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif
`ifndef PID_SPEED_FREQ
`define PID_SPEED_FREQ 1000
`endif
`ifndef QEI_RES
`define QEI_RES 16
`endif
`ifndef PID_RES
`define PID_RES 16
`endif

module speed_sampler #(
  parameter int             nch         = 2,
  parameter int             clk_freq    = `CLK_FREQ,
  parameter int             sample_freq = `PID_SPEED_FREQ,
  parameter int             qei_res     = `QEI_RES,
  parameter int             pv_res      = `PID_RES,
  parameter int             ramp_max    = 0,
  parameter logic [nch-1:0] invert      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [nch-1:0]        A_i,
  input  logic [nch-1:0]        B_i,
  input  logic [nch*pv_res-1:0] sp_i,
  output logic [nch*pv_res-1:0] pv_o,
  output logic [nch*pv_res-1:0] sp_o,
  output logic                  valid_o,
  output logic [nch-1:0]        ovf_o,
  output logic [nch-1:0]        err_o
);

  localparam int div  = clk_freq / sample_freq;
  localparam int divW = $clog2(div);
  localparam logic signed [pv_res:0] rampPos = (pv_res+1)'(ramp_max);
  localparam logic signed [pv_res:0] rampNeg = (pv_res+1)'(-ramp_max);

  logic [nch-1:0] aSync1, aSync2, aPrev;
  logic [nch-1:0] bSync1, bSync2, bPrev;
  logic [1:0]     inhibitCnt;
  logic [divW-1:0] divCnt;
  logic signed [qei_res-1:0] acc    [nch];
  logic signed [qei_res-1:0] accSat [nch];
  logic [pv_res-1:0]         spNext [nch];
  logic [nch-1:0]  satStep, illegal;
  logic            decodeOn, tick;

  assign decodeOn = (inhibitCnt == 2'd3);
  assign tick     = en && (divCnt == divW'(div - 1));

  always_comb begin
    logic [1:0]              move;
    logic signed [1:0]       delta;
    logic [qei_res:0]        sum;
    logic signed [pv_res:0]  diff;
    logic [pv_res-1:0]       spTgt, spCur;
    move  = '0;
    delta = '0;
    sum   = '0;
    diff  = '0;
    spTgt = '0;
    spCur = '0;
    satStep = '0;
    illegal = '0;
    for (int k = 0; k < nch; k++) begin
      // Gray state {A,B} mapped to a 2-bit position so the step is a plain difference
      move  = {aSync2[k], aSync2[k] ^ bSync2[k]} - {aPrev[k], aPrev[k] ^ bPrev[k]};
      delta = '0;
      if (decodeOn) begin
        case (move)
          2'b01:   delta = 2'sb01;
          2'b11:   delta = 2'sb11;
          2'b10:   illegal[k] = 1'b1;
          default: delta = '0;
        endcase
      end
      if (invert[k]) delta = -delta;

      sum = {acc[k][qei_res-1], acc[k]} + {{(qei_res-1){delta[1]}}, delta};
      if (sum[qei_res] != sum[qei_res-1]) begin
        satStep[k] = en;
        accSat[k]  = sum[qei_res] ? {1'b1, {(qei_res-1){1'b0}}} : {1'b0, {(qei_res-1){1'b1}}};
      end else begin
        accSat[k]  = sum[qei_res-1:0];
      end

      spTgt = sp_i[k*pv_res +: pv_res];
      spCur = sp_o[k*pv_res +: pv_res];
      diff  = {spTgt[pv_res-1], spTgt} - {spCur[pv_res-1], spCur};
      if (ramp_max == 0 || (diff <= rampPos && diff >= rampNeg))
        spNext[k] = spTgt;
      else if (diff > rampPos)
        spNext[k] = spCur + pv_res'(ramp_max);
      else
        spNext[k] = spCur - pv_res'(ramp_max);
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aSync1     <= '0;
      aSync2     <= '0;
      aPrev      <= '0;
      bSync1     <= '0;
      bSync2     <= '0;
      bPrev      <= '0;
      inhibitCnt <= '0;
      divCnt     <= '0;
      pv_o       <= '0;
      sp_o       <= '0;
      valid_o    <= 1'b0;
      ovf_o      <= '0;
      err_o      <= '0;
      for (int k = 0; k < nch; k++) acc[k] <= '0;
    end else begin
      aSync1 <= A_i;
      aSync2 <= aSync1;
      aPrev  <= aSync2;
      bSync1 <= B_i;
      bSync2 <= bSync1;
      bPrev  <= bSync2;
      if (!decodeOn) inhibitCnt <= inhibitCnt + 2'd1;

      if (clr) begin
        divCnt  <= '0;
        pv_o    <= '0;
        sp_o    <= '0;
        valid_o <= 1'b0;
        ovf_o   <= '0;
        err_o   <= '0;
        for (int k = 0; k < nch; k++) acc[k] <= '0;
      end else begin
        valid_o <= tick;
        ovf_o   <= ovf_o | satStep;
        err_o   <= err_o | illegal;
        if (en) divCnt <= tick ? '0 : divCnt + divW'(1);
        for (int k = 0; k < nch; k++) begin
          if (tick) begin
            acc[k]                   <= '0;
            pv_o[k*pv_res +: pv_res] <= pv_res'(accSat[k]);
            sp_o[k*pv_res +: pv_res] <= spNext[k];
          end else if (en) begin
            acc[k] <= accSat[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_speed_sampler.sv
// Bench for speed_sampler: instance A (div 10, no invert, no ramp limit) and
// instance B (div 250 so 200 steps fit one period, invert 2'b10, ramp 100).
module tb_speed_sampler;

  typedef struct {
    logic [31:0] pv;
    logic [31:0] sp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enIn    [2];
  logic        clrIn   [2];
  logic [1:0]  aIn     [2];
  logic [1:0]  bIn     [2];
  logic [31:0] spIn    [2];
  logic [31:0] pvOut   [2];
  logic [31:0] spOut   [2];
  logic        validOut[2];
  logic [1:0]  ovfOut  [2];
  logic [1:0]  errOut  [2];
  logic [1:0]  pos     [2][2];

  exp_t qA[$];
  exp_t qB[$];
  int   total  = 0;
  int   passed = 0;
  logic sawEarly;

  always #5 clk = ~clk;

  speed_sampler #(
    .nch(2), .clk_freq(1000), .sample_freq(100), .qei_res(8), .pv_res(16),
    .ramp_max(0), .invert(2'b00)
  ) dutA (
    .clk(clk), .rst(rst), .clr(clrIn[0]), .en(enIn[0]), .A_i(aIn[0]), .B_i(bIn[0]),
    .sp_i(spIn[0]), .pv_o(pvOut[0]), .sp_o(spOut[0]), .valid_o(validOut[0]),
    .ovf_o(ovfOut[0]), .err_o(errOut[0])
  );

  speed_sampler #(
    .nch(2), .clk_freq(1000), .sample_freq(4), .qei_res(8), .pv_res(16),
    .ramp_max(100), .invert(2'b10)
  ) dutB (
    .clk(clk), .rst(rst), .clr(clrIn[1]), .en(enIn[1]), .A_i(aIn[1]), .B_i(bIn[1]),
    .sp_i(spIn[1]), .pv_o(pvOut[1]), .sp_o(spOut[1]), .valid_o(validOut[1]),
    .ovf_o(ovfOut[1]), .err_o(errOut[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic pushExp(input int d, input logic [31:0] pv, input logic [31:0] sp);
    exp_t e;
    e.pv = pv;
    e.sp = sp;
    if (d == 0) qA.push_back(e);
    else        qB.push_back(e);
  endtask

  task automatic step(input int d, input int ch, input int dir);
    pos[d][ch]    = pos[d][ch] + 2'(dir);
    aIn[d][ch]    = pos[d][ch][1];
    bIn[d][ch]    = pos[d][ch][1] ^ pos[d][ch][0];
  endtask

  task automatic runWindow(input int d, input int n, input int s0, input int d0,
                           input int s1, input int d1);
    @(negedge clk);
    enIn[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i < s0) step(d, 0, d0);
      if (i < s1) step(d, 1, d1);
      @(posedge clk);
      @(negedge clk);
    end
    enIn[d] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulseClr(input int d);
    @(negedge clk);
    clrIn[d] = 1'b1;
    @(negedge clk);
    clrIn[d] = 1'b0;
  endtask

  // Scoreboard monitor: every valid_o pulse consumes one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (validOut[0]) begin
      check("A_valid_expected", 64'(qA.size() > 0), 64'd1);
      if (qA.size() > 0) begin
        e = qA.pop_front();
        check("A_pv", 64'(pvOut[0]), 64'(e.pv));
        check("A_sp", 64'(spOut[0]), 64'(e.sp));
      end
    end
    if (validOut[1]) begin
      check("B_valid_expected", 64'(qB.size() > 0), 64'd1);
      if (qB.size() > 0) begin
        e = qB.pop_front();
        check("B_pv", 64'(pvOut[1]), 64'(e.pv));
        check("B_sp", 64'(spOut[1]), 64'(e.sp));
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      enIn[d]  = 1'b0;
      clrIn[d] = 1'b0;
      aIn[d]   = '0;
      bIn[d]   = '0;
      spIn[d]  = '0;
      pos[d][0] = '0;
      pos[d][1] = '0;
    end

    repeat (2) @(negedge clk);
    check("reset_A_pv",    64'(pvOut[0]), 64'd0);
    check("reset_A_sp",    64'(spOut[0]), 64'd0);
    check("reset_A_valid", 64'(validOut[0]), 64'd0);
    check("reset_A_ovf",   64'(ovfOut[0]), 64'd0);
    check("reset_A_err",   64'(errOut[0]), 64'd0);
    check("reset_B_pv",    64'(pvOut[1]), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // A: 7 forward on ch0, 3 reverse on ch1
    pushExp(0, {16'hFFFD, 16'd7}, 32'd0);
    runWindow(0, 10, 7, 1, 3, -1);
    check("A_err_after_legal", 64'(errOut[0]), 64'd0);
    check("A_ovf_after_small", 64'(ovfOut[0]), 64'd0);

    // A: unlimited ramp follows sp_i in one sample
    spIn[0] = {16'hFF38, 16'd350};
    pushExp(0, 32'd0, {16'hFF38, 16'd350});
    runWindow(0, 10, 0, 0, 0, 0);

    // B: inverted ch1, 5 forward steps each
    pushExp(1, {16'hFFFB, 16'd5}, 32'd0);
    runWindow(1, 250, 5, 1, 5, 1);
    check("B_ovf_after_invert", 64'(ovfOut[1]), 64'd0);

    // B: ramp 0 -> 350 then -> -50, limit 100 per sample
    spIn[1] = {16'd0, 16'd350};
    pushExp(1, 32'd0, {16'd0, 16'd100});
    pushExp(1, 32'd0, {16'd0, 16'd200});
    pushExp(1, 32'd0, {16'd0, 16'd300});
    pushExp(1, 32'd0, {16'd0, 16'd350});
    runWindow(1, 1000, 0, 0, 0, 0);
    spIn[1] = {16'd0, 16'hFFCE};
    pushExp(1, 32'd0, {16'd0, 16'd250});
    pushExp(1, 32'd0, {16'd0, 16'd150});
    pushExp(1, 32'd0, {16'd0, 16'd50});
    pushExp(1, 32'd0, {16'd0, 16'hFFCE});
    runWindow(1, 1000, 0, 0, 0, 0);

    // B: clr zeroes sp_o, then saturation with 200 forward steps
    spIn[1] = '0;
    pulseClr(1);
    check("B_clr_sp", 64'(spOut[1]), 64'd0);
    check("B_clr_pv", 64'(pvOut[1]), 64'd0);
    pushExp(1, {16'd0, 16'd127}, 32'd0);
    runWindow(1, 250, 200, 1, 0, 0);
    check("B_ovf_set", 64'(ovfOut[1]), 64'd1);
    pushExp(1, 32'd0, 32'd0);
    runWindow(1, 250, 0, 0, 0, 0);
    check("B_ovf_held", 64'(ovfOut[1]), 64'd1);
    pulseClr(1);
    check("B_ovf_cleared", 64'(ovfOut[1]), 64'd0);

    // A: illegal jump on ch0 sets err, count unchanged
    pushExp(0, 32'd0, {16'hFF38, 16'd350});
    runWindow(0, 10, 1, 2, 0, 0);
    check("A_err_set", 64'(errOut[0]), 64'd1);

    // A: rst mid-period forces everything to zero at once
    @(negedge clk);
    enIn[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_A_pv",    64'(pvOut[0]), 64'd0);
    check("rst_A_sp",    64'(spOut[0]), 64'd0);
    check("rst_A_valid", 64'(validOut[0]), 64'd0);
    check("rst_A_err",   64'(errOut[0]), 64'd0);
    check("rst_A_ovf",   64'(ovfOut[0]), 64'd0);
    check("rst_B_sp",    64'(spOut[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pushExp(0, 32'd0, {16'hFF38, 16'd350});
    sawEarly = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 10) sawEarly = sawEarly | validOut[0];
    end
    check("A_no_early_valid", 64'(sawEarly), 64'd0);
    check("A_valid_at_10",    64'(validOut[0]), 64'd1);
    enIn[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("A_err_after_rst", 64'(errOut[0]), 64'd0);

    // A: steps while disabled are not counted and produce no valid_o
    sawEarly = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i < 4) step(0, 0, 1);
      @(posedge clk);
      @(negedge clk);
      sawEarly = sawEarly | validOut[0];
    end
    check("A_no_valid_disabled", 64'(sawEarly), 64'd0);
    pushExp(0, 32'd0, {16'hFF38, 16'd350});
    runWindow(0, 10, 0, 0, 0, 0);

    check("A_queue_drained", 64'(qA.size()), 64'd0);
    check("B_queue_drained", 64'(qB.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/speed_sampler.md
SPEED_SAMPLER -- requirements
Module: speed_sampler

Interface
REQ-001 Parameter nch, 2: number of encoder channels, range 1..8.
REQ-002 Parameter clk_freq, `CLK_FREQ: system clock frequency in Hz.
REQ-003 Parameter sample_freq, `PID_SPEED_FREQ: sampling rate in Hz; div = floor(clk_freq/sample_freq), div >= 2.
REQ-004 Parameter qei_res, `QEI_RES: signed accumulator width per channel.
REQ-005 Parameter pv_res, `PID_RES: signed width of pv/sp words, pv_res >= qei_res.
REQ-006 Parameter ramp_max, 0: maximum sp_o change per sample; 0 means no limit.
REQ-007 Parameter invert, 0: nch-bit mask; bit k set negates the count direction of channel k.
REQ-008 clk  in  1  system clock; the block uses this single clock.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 clr  in  1  synchronous clear.
REQ-011 en  in  1  counting and sampling enable.
REQ-012 A_i, B_i  in  nch each  raw quadrature inputs, bit k = channel k, asynchronous to clk.
REQ-013 sp_i  in  nch*pv_res  target speed, channel k at [k*pv_res +: pv_res], signed.
REQ-014 pv_o  out  nch*pv_res  measured counts per sample period, signed, same packing.
REQ-015 sp_o  out  nch*pv_res  ramp-limited setpoint, signed, same packing.
REQ-016 valid_o  out  1  one-cycle strobe: pv_o and sp_o updated.
REQ-017 ovf_o  out  nch  sticky accumulator saturation flag per channel.
REQ-018 err_o  out  nch  sticky illegal-transition flag per channel.

Function
REQ-019 Each A/B input SHALL pass through a two-flop synchronizer, then a previous-state register.
REQ-020 Decode on {A,B}: 00->01->11->10->00 = +1, reverse order = -1, no change = 0, both bits changed = 0 and err_o[k] set.
REQ-021 Delta SHALL be negated when invert[k] = 1.
REQ-022 Decoding is inhibited for the first 3 clk cycles after reset release (synchronizer fill); no count or err during this window.
REQ-023 A pin edge SHALL reach the accumulator 3 cycles after it is present at the synchronizer input.
REQ-024 Accumulator saturates at +(2^(qei_res-1)-1) and -(2^(qei_res-1)); a saturating step sets ovf_o[k].
REQ-025 Divider counts 0..div-1 while en = 1; tick asserts in the cycle where count = div-1, then count wraps to 0.
REQ-026 On tick: pv_o[k] <= sign-extension to pv_res of (acc + delta of that cycle, saturated); acc <= 0; valid_o = 1 the next cycle, concurrent with the new pv_o.
REQ-027 On tick: diff = sp_i[k] - sp_o[k] computed in pv_res+1 bits; if ramp_max = 0 or |diff| <= ramp_max then sp_o[k] <= sp_i[k], else sp_o[k] moves ramp_max toward sp_i[k].
REQ-028 en = 0: divider and accumulators hold, no tick, valid_o = 0; synchronizers and previous-state registers keep tracking, so re-enabling produces no spurious count.
REQ-029 clr = 1: divider, accumulators, pv_o, sp_o, valid_o, ovf_o, err_o <= 0 next edge; clr has priority over tick and en.
REQ-030 ovf_o and err_o SHALL clear only on rst or clr.

Reset
REQ-031 rst asserted SHALL immediately force pv_o, sp_o, valid_o, ovf_o, err_o, accumulators, divider, synchronizers, previous-state registers and inhibit counter to 0, mid-operation included.
REQ-032 After rst deasserts, the first tick SHALL occur div cycles after the first clk edge with en = 1.

Verification (bench: nch=2, clk_freq=1000, sample_freq=100 so div=10, qei_res=8, pv_res=16)
REQ-033 Ch0 fed 7 forward steps and ch1 fed 3 reverse steps within one period -> valid_o pulse with pv_o ch0 = 7, ch1 = 0xFFFD.
REQ-034 invert=2'b10, both channels get 5 forward steps -> pv_o ch0 = 5, ch1 = 0xFFFB.
REQ-035 ramp_max=100, sp_i ch0 step 0 -> 350 -> sp_o ch0 = 100, 200, 300, 350 on successive valid_o pulses; then step to -50 -> 250, 150, 50, -50.
REQ-036 Ch0 200 forward steps in one period -> pv_o ch0 = 127, ovf_o[0] = 1, held after the next period until clr pulse clears it.
REQ-037 Ch0 input jumps 00->11 -> err_o[0] = 1, count unchanged; rst asserted mid-period -> all outputs 0 at once, no valid_o until 10 enabled cycles after release.
REQ-038 en low for 25 cycles with 4 steps applied -> no valid_o, count unchanged; en high again -> next pv_o ch0 = 0.
